pwm_multi: RTL and testbench

- Multi-channel PWM generator. It is the parametrised successor to the team's single-channel 8-bit PWM block.
- One shared period counter drives C_NUM_CHANNELS independent outputs. Each output has its own duty, enable and double-buffered update.
- Duty resolution is configurable. Duty scaling is exact, and duty full-scale gives 100% high.
- Edge-aligned or center-aligned mode is selectable. A period-start strobe lets downstream ADC/sequencing logic synchronise to the PWM.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_channel.sv | 68 ++++++
 rtl/pwm_multi.sv | 63 ++++++
 tb/tb_pwm_multi.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel PWM.
package pwm_pkg;

  typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} mode_t;

  function automatic int calc_period_count(input longint clk_hz, input longint period_us);
    return int'((clk_hz / 64'd1000000) * period_us);
  endfunction

  function automatic int calc_count_w(input int period_count);
    return $clog2(period_count);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: double-buffered duty, enable arming, window compare, output register.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int PERIOD_COUNT = 100,
  parameter int COUNT_W      = 7,
  parameter int DUTY_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [COUNT_W-1:0]   counter,
  input  logic                 boundary,
  input  logic                 center,
  input  logic [DUTY_BITS-1:0] duty,
  input  logic                 valid,
  input  logic                 enable,
  output logic                 pwm
);

  localparam int PW = COUNT_W + DUTY_BITS;
  // One extra bit so a full-scale compare equal to PERIOD_COUNT always fits.
  localparam int CW = COUNT_W + 1;
  localparam logic [PW-1:0]        PC_P   = PW'(PERIOD_COUNT);
  localparam logic [CW-1:0]        PC_C   = CW'(PERIOD_COUNT);
  localparam logic [DUTY_BITS-1:0] D_FULL = '1;

  logic [DUTY_BITS-1:0] pending, active;
  logic                 pend_flag, armed;
  logic [PW-1:0]        prod;
  logic [CW-1:0]        cmp, lo, cnt_x;
  logic                 in_win;

  always_comb begin
    prod   = PW'(active) * PC_P;
    cmp    = (active == D_FULL) ? PC_C : CW'(prod >> DUTY_BITS);
    lo     = center ? ((PC_C - cmp) >> 1) : '0;
    cnt_x  = {1'b0, counter};
    in_win = (cnt_x >= lo) && (cnt_x < lo + cmp);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending   <= '0;
      active    <= '0;
      pend_flag <= 1'b0;
      armed     <= 1'b0;
      pwm       <= 1'b0;
    end else begin
      if (valid) begin
        pending   <= duty;
        pend_flag <= 1'b1;
      end
      // A write in the boundary cycle bypasses pending so it lands on this boundary.
      if (boundary) begin
        if (valid)          active <= duty;
        else if (pend_flag) active <= pending;
        pend_flag <= 1'b0;
      end else if (!armed) begin
        active <= pending;
        if (!valid) pend_flag <= 1'b0;
      end
      if (!enable)       armed <= 1'b0;
      else if (boundary) armed <= 1'b1;
      pwm <= armed & enable & in_win;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter, boundary decode, mode latch, period strobe.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int C_CLK_FREQ_HZ   = 100000000,
  parameter int C_PWM_PERIOD_US = 200,
  parameter int C_NUM_CHANNELS  = 4,
  parameter int C_DUTY_BITS     = 8
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [C_NUM_CHANNELS*C_DUTY_BITS-1:0] duty_cycle,
  input  logic [C_NUM_CHANNELS-1:0]             duty_cycle_valid,
  input  logic [C_NUM_CHANNELS-1:0]             enable,
  input  logic                                  center_aligned,
  output logic [C_NUM_CHANNELS-1:0]             pwm,
  output logic                                  period_start
);

  localparam int PERIOD_COUNT = calc_period_count(C_CLK_FREQ_HZ, C_PWM_PERIOD_US);
  localparam int COUNT_W      = calc_count_w(PERIOD_COUNT);
  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(PERIOD_COUNT - 1);

  logic [COUNT_W-1:0]                         counter;
  logic                                       boundary;
  mode_t                                      mode;
  logic [C_NUM_CHANNELS-1:0][C_DUTY_BITS-1:0] duty_v;

  assign boundary = (counter == LAST);
  assign duty_v   = duty_cycle;

  // period_start is registered alongside pwm so both reflect the same counter value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      counter      <= '0;
      mode         <= PWM_EDGE;
      period_start <= 1'b0;
    end else begin
      counter      <= boundary ? '0 : counter + COUNT_W'(1);
      period_start <= (counter == '0);
      if (boundary) mode <= center_aligned ? PWM_CENTER : PWM_EDGE;
    end
  end

  for (genvar i = 0; i < C_NUM_CHANNELS; i++) begin : g_ch
    pwm_channel #(
      .PERIOD_COUNT (PERIOD_COUNT),
      .COUNT_W      (COUNT_W),
      .DUTY_BITS    (C_DUTY_BITS)
    ) u_ch (
      .clk      (clk),
      .resetn   (resetn),
      .counter  (counter),
      .boundary (boundary),
      .center   (mode == PWM_CENTER),
      .duty     (duty_v[i]),
      .valid    (duty_cycle_valid[i]),
      .enable   (enable[i]),
      .pwm      (pwm[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: 100-cycle period, 8-bit duty, two channels.
module tb_pwm_multi;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] duty_cycle = '0;
  logic [1:0]  duty_cycle_valid = '0;
  logic [1:0]  enable = '0;
  logic        center_aligned = 1'b0;
  logic [1:0]  pwm;
  logic        period_start;

  int checks = 0, failures = 0;
  int tb_cnt = 0;
  int hi0, hi1, f0, l0, ps_bad, cnt;

  pwm_multi #(
    .C_CLK_FREQ_HZ   (10000000),
    .C_PWM_PERIOD_US (10),
    .C_NUM_CHANNELS  (2),
    .C_DUTY_BITS     (8)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .duty_cycle       (duty_cycle),
    .duty_cycle_valid (duty_cycle_valid),
    .enable           (enable),
    .center_aligned   (center_aligned),
    .pwm              (pwm),
    .period_start     (period_start)
  );

  always #5 clk = ~clk;

  // Reference period counter; at a negedge with tb_cnt==k+1, pwm reflects counter k.
  always @(posedge clk or negedge resetn)
    if (!resetn) tb_cnt <= 0;
    else         tb_cnt <= (tb_cnt == 99) ? 0 : tb_cnt + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cnt(input int v);
    int n = 0;
    while (tb_cnt != v && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (tb_cnt != v) begin
      checks++;
      failures++;
      $display("FAIL wait_cnt observed=%0d expected=%0d", tb_cnt, v);
    end
  endtask

  task automatic load(input int ch, input logic [7:0] d);
    duty_cycle[ch*8 +: 8] = d;
    duty_cycle_valid[ch]  = 1'b1;
    @(negedge clk);
    duty_cycle_valid = '0;
  endtask

  // Samples one full period (counters 0..99); optionally pulses a valid when tb_cnt==inj_cnt.
  task automatic measure(input int inj_cnt, input int inj_ch, input logic [7:0] inj_d);
    hi0 = 0; hi1 = 0; f0 = -1; l0 = -1; ps_bad = 0;
    wait_cnt(1);
    for (int k = 0; k < 100; k++) begin
      if (pwm[0]) begin
        hi0++;
        if (f0 < 0) f0 = k;
        l0 = k;
      end
      if (pwm[1]) hi1++;
      if (period_start !== (k == 0)) ps_bad++;
      duty_cycle_valid = '0;
      if (tb_cnt == inj_cnt) begin
        duty_cycle[inj_ch*8 +: 8] = inj_d;
        duty_cycle_valid[inj_ch]  = 1'b1;
      end
      @(negedge clk);
    end
    duty_cycle_valid = '0;
  endtask

  initial begin
    #3;
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_ps", int'(period_start), 0);
    chk("rst_cnt", int'(dut.counter), 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Edge mode: ch0 D=128 (cmp 50), ch1 D=255 (100%)
    duty_cycle = {8'd255, 8'd128};
    duty_cycle_valid = 2'b11;
    enable = 2'b11;
    @(negedge clk);
    duty_cycle_valid = '0;
    wait_cnt(50);
    measure(-1, 0, 8'd0);
    chk("edge_hi0", hi0, 50);
    chk("edge_first0", f0, 0);
    chk("edge_last0", l0, 49);
    chk("full_hi1", hi1, 100);
    chk("edge_ps", ps_bad, 0);

    measure(10, 0, 8'd0);
    chk("keep_hi0", hi0, 50);
    chk("full_hi1_b", hi1, 100);
    measure(10, 1, 8'd1);
    chk("d0_hi0", hi0, 0);
    chk("full_hi1_c", hi1, 100);

    // Center mode, D=64 -> cmp 25, lo 37
    center_aligned = 1'b1;
    load(0, 8'd64);
    measure(-1, 0, 8'd0);
    chk("ctr_hi0", hi0, 25);
    chk("ctr_first0", f0, 37);
    chk("ctr_last0", l0, 61);
    chk("d1_hi1", hi1, 0);
    chk("ctr_ps", ps_bad, 0);

    // Back to edge; double-buffered writes mid-period and in the boundary cycle
    center_aligned = 1'b0;
    load(0, 8'd128);
    measure(-1, 0, 8'd0);
    chk("edge2_hi0", hi0, 50);
    chk("edge2_first0", f0, 0);
    measure(30, 0, 8'd192);
    chk("mid_write_hi0", hi0, 50);
    measure(99, 0, 8'd10);
    chk("d192_hi0", hi0, 75);
    chk("d192_last0", l0, 74);
    measure(-1, 0, 8'd0);
    chk("d10_hi0", hi0, 3);
    chk("d10_last0", l0, 2);

    // Enable fall at counter 20, rise at counter 40
    load(0, 8'd128);
    wait_cnt(50);
    wait_cnt(20);
    chk("en_pre", int'(pwm[0]), 1);
    enable[0] = 1'b0;
    @(negedge clk);
    chk("en_fall", int'(pwm[0]), 0);
    wait_cnt(40);
    enable[0] = 1'b1;
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 200 && tb_cnt != 1; k++) begin
      if (pwm[0]) cnt++;
      @(negedge clk);
    end
    chk("en_runt", cnt, 0);
    measure(-1, 0, 8'd0);
    chk("en_rise_hi0", hi0, 50);
    chk("en_rise_first0", f0, 0);

    // Asynchronous reset while pwm is high
    wait_cnt(26);
    chk("pre_rst_pwm0", int'(pwm[0]), 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_pwm", int'(pwm), 0);
    chk("async_rst_ps", int'(period_start), 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rel_cnt", int'(dut.counter), 0);
    wait_cnt(50);
    measure(-1, 0, 8'd0);
    chk("post_rst_hi0", hi0, 0);
    chk("post_rst_hi1", hi1, 0);
    load(0, 8'd128);
    measure(-1, 0, 8'd0);
    chk("rearm_hi0", hi0, 50);
    chk("rearm_first0", f0, 0);
    chk("rearm_ps", ps_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
